// File: rtl/vga_text_renderer_pkg.sv
// Shared definitions for the VGA text renderer.
//   PIPE_LATENCY : cycles from pixel inputs to RGB/sync outputs
//   CELL_SHIFT   : log2 of the 8x8 character cell size
//   COLOR_*      : 3-bit {R,G,B} constants
//   sideband_t   : per-pixel data carried alongside the memory fetches
package vga_text_renderer_pkg;

  localparam int PIPE_LATENCY = 5;
  localparam int CELL_SHIFT   = 3;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  typedef struct packed {
    logic [2:0] glyph_row;
    logic [2:0] glyph_col;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       cursor_hit;
  } sideband_t;

  // Flushed stage: blanked pixel with inactive (high) syncs.
  localparam sideband_t SIDEBAND_IDLE = '{
    glyph_row:  3'd0,
    glyph_col:  3'd0,
    hsync:      1'b1,
    vsync:      1'b1,
    de:         1'b0,
    cursor_hit: 1'b0
  };

endpackage

// File: rtl/vga_text_renderer_if.sv
// Memory bus between the renderer and its text RAM / font ROM.
//   oTextAddr : text RAM read address (renderer drives)
//   iTextData : character code, valid one cycle after oTextAddr
//   oFontAddr : font ROM address {char, glyphRow} (renderer drives)
//   iFontData : glyph row bits, MSB = leftmost, valid one cycle after oFontAddr
// Both memories are synchronous read-only ports with no handshake: the
// renderer presents a new address every cycle and the memory must return
// the addressed data exactly one cycle later, unconditionally.
interface vga_text_renderer_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] oTextAddr;
  logic [7:0]            iTextData;
  logic [10:0]           oFontAddr;
  logic [7:0]            iFontData;

  modport master (output oTextAddr, output oFontAddr,
                  input  iTextData, input  iFontData);
  modport slave  (input  oTextAddr, input  oFontAddr,
                  output iTextData, output iFontData);
endinterface

// File: rtl/vga_text_renderer_blink.sv
// Cursor blink timer.
//   Clock, Reset : pixel clock, synchronous active-high reset
//   iVSync       : vertical sync from the timing controller, active-low
//   oBlinkPhase  : cursor overlay enable, toggles every BLINK_FRAMES frames
// A frame is counted on each falling edge of iVSync.
module vga_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iVSync,
  output logic oBlinkPhase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             phase_q, phase_d;
  logic             vsync_prev_q;
  logic             vsync_fall;

  always_comb begin
    vsync_fall  = vsync_prev_q & ~iVSync;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (vsync_fall) begin
      if (frame_cnt_q == LAST_FRAME) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Reset also forces the previous-vsync register high, so an edge that
  // lines up with Reset is never counted.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      frame_cnt_q  <= '0;
      phase_q      <= 1'b1;
      vsync_prev_q <= 1'b1;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      vsync_prev_q <= iVSync;
    end
  end

  assign oBlinkPhase = phase_q;

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode pixel generator fed by the VGA timing controller.
//   Clock, Reset         : pixel clock, synchronous active-high reset
//   iCol, iRow           : current pixel position
//   iHSync, iVSync       : syncs (active-low), iDisplayEnable: visible area
//   iFgColor, iBgColor   : colours, sampled at the output stage only
//   iCursorCol/Row       : block cursor cell
//   mem                  : text RAM / font ROM bus (master side)
//   oRed/oGreen/oBlue    : pixel colour; oHSync/oVSync: syncs delayed 5 cycles
// Five-stage pipeline: 1 text address, 2 text RAM read, 3 font address,
// 4 font ROM read, 5 output pixel. All sideband travels with the pixel so
// every output lags its input by exactly five cycles.
module vga_text_renderer
  import vga_text_renderer_pkg::*;
#(
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 8,
  parameter int COLS         = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [X_WIDTH-1:0]           iCol,
  input  logic [Y_WIDTH-1:0]           iRow,
  input  logic                         iHSync,
  input  logic                         iVSync,
  input  logic                         iDisplayEnable,
  input  logic [2:0]                   iFgColor,
  input  logic [2:0]                   iBgColor,
  input  logic [X_WIDTH-CELL_SHIFT-1:0] iCursorCol,
  input  logic [Y_WIDTH-CELL_SHIFT-1:0] iCursorRow,
  vga_text_renderer_if.master          mem,
  output logic                         oRed,
  output logic                         oGreen,
  output logic                         oBlue,
  output logic                         oHSync,
  output logic                         oVSync
);

  logic [X_WIDTH-CELL_SHIFT-1:0] char_col;
  logic [Y_WIDTH-CELL_SHIFT-1:0] char_row;
  logic [ADDR_WIDTH-1:0]         text_addr_d, text_addr_q;
  logic [10:0]                   font_addr_d, font_addr_q;
  sideband_t                     sb1_d;
  sideband_t                     sb_q [4];  // index 0..3 = stages 1..4
  logic                          pix_bit, pix_on, blink_phase;
  logic [2:0]                    rgb_d, rgb_q;
  logic                          hsync_q, vsync_q;

  vga_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .Clock       (Clock),
    .Reset       (Reset),
    .iVSync      (iVSync),
    .oBlinkPhase (blink_phase)
  );

  always_comb begin
    char_col = iCol[X_WIDTH-1:CELL_SHIFT];
    char_row = iRow[Y_WIDTH-1:CELL_SHIFT];
    // Row-major cell index; the cast drops any bits beyond the RAM size.
    text_addr_d = ADDR_WIDTH'(32'(char_row) * 32'(COLS) + 32'(char_col));

    sb1_d.glyph_row  = iRow[CELL_SHIFT-1:0];
    sb1_d.glyph_col  = iCol[CELL_SHIFT-1:0];
    sb1_d.hsync      = iHSync;
    sb1_d.vsync      = iVSync;
    sb1_d.de         = iDisplayEnable;
    sb1_d.cursor_hit = (char_col == iCursorCol) && (char_row == iCursorRow);

    // Text RAM data belongs to the pixel currently in stage 2.
    font_addr_d = {mem.iTextData, sb_q[1].glyph_row};

    // Font ROM data belongs to the pixel currently in stage 4.
    pix_bit = mem.iFontData[3'd7 - sb_q[3].glyph_col];
    pix_on  = pix_bit ^ (sb_q[3].cursor_hit & blink_phase);
    rgb_d   = COLOR_BLACK;
    if (sb_q[3].de) rgb_d = pix_on ? iFgColor : iBgColor;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      text_addr_q <= '0;
      font_addr_q <= '0;
      for (int i = 0; i < 4; i++) sb_q[i] <= SIDEBAND_IDLE;
      rgb_q       <= COLOR_BLACK;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      text_addr_q <= text_addr_d;
      sb_q[0]     <= sb1_d;
      sb_q[1]     <= sb_q[0];
      font_addr_q <= font_addr_d;
      sb_q[2]     <= sb_q[1];
      sb_q[3]     <= sb_q[2];
      rgb_q       <= rgb_d;
      hsync_q     <= sb_q[3].hsync;
      vsync_q     <= sb_q[3].vsync;
    end
  end

  assign mem.oTextAddr = text_addr_q;
  assign mem.oFontAddr = font_addr_q;
  assign oRed   = rgb_q[2];
  assign oGreen = rgb_q[1];
  assign oBlue  = rgb_q[0];
  assign oHSync = hsync_q;
  assign oVSync = vsync_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: main instance (ADDR_WIDTH 10, BLINK_FRAMES 2)
// plus a second instance with ADDR_WIDTH 4 sharing the same pixel inputs.
module tb_vga_text_renderer;
  import vga_text_renderer_pkg::*;

  localparam int COLS         = 32;
  localparam int BLINK_FRAMES = 2;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  logic [7:0] col, row;
  logic       hs, vs, de;
  logic [2:0] fg, bg;
  logic [4:0] cur_col, cur_row;
  logic       red, green, blue, hso, vso;
  logic       t_red, t_green, t_blue, t_hso, t_vso;

  vga_text_renderer_if #(.ADDR_WIDTH(10)) mem_if ();
  vga_text_renderer_if #(.ADDR_WIDTH(4))  trunc_if ();

  vga_text_renderer #(.X_WIDTH(8), .Y_WIDTH(8), .COLS(COLS), .ADDR_WIDTH(10),
                      .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .Clock(Clock), .Reset(Reset), .iCol(col), .iRow(row), .iHSync(hs), .iVSync(vs),
    .iDisplayEnable(de), .iFgColor(fg), .iBgColor(bg), .iCursorCol(cur_col),
    .iCursorRow(cur_row), .mem(mem_if), .oRed(red), .oGreen(green), .oBlue(blue),
    .oHSync(hso), .oVSync(vso)
  );

  vga_text_renderer #(.X_WIDTH(8), .Y_WIDTH(8), .COLS(COLS), .ADDR_WIDTH(4),
                      .BLINK_FRAMES(BLINK_FRAMES)) u_trunc (
    .Clock(Clock), .Reset(Reset), .iCol(col), .iRow(row), .iHSync(hs), .iVSync(vs),
    .iDisplayEnable(de), .iFgColor(fg), .iBgColor(bg), .iCursorCol(cur_col),
    .iCursorRow(cur_row), .mem(trunc_if), .oRed(t_red), .oGreen(t_green),
    .oBlue(t_blue), .oHSync(t_hso), .oVSync(t_vso)
  );

  // ---------------- memory models (1-cycle synchronous read) ----------------
  logic [7:0] text_mem [0:1023];
  logic [7:0] font_mem [0:2047];

  always @(posedge Clock) begin
    mem_if.iTextData <= text_mem[mem_if.oTextAddr];
    mem_if.iFontData <= font_mem[mem_if.oFontAddr];
  end

  initial begin
    trunc_if.iTextData = 8'h00;
    trunc_if.iFontData = 8'h00;
  end

  // ---------------- scoreboard ----------------
  logic [4:0] exp_q[$];  // {hsync, vsync, rgb}
  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference blink state, advanced as vsync stimulus is driven.
  logic m_phase, m_prev;
  int   m_cnt;

  function automatic logic [4:0] model_pixel(input logic [7:0] c, input logic [7:0] r,
                                             input logic h, input logic v, input logic d);
    int         a;
    logic [7:0] code, g;
    logic       b, hit, on;
    logic [2:0] rgb;
    a    = (int'(r) / 8) * COLS + (int'(c) / 8);
    code = text_mem[a];
    g    = font_mem[int'(code) * 8 + (int'(r) % 8)];
    b    = g[7 - (int'(c) % 8)];
    hit  = (int'(c) / 8 == int'(cur_col)) && (int'(r) / 8 == int'(cur_row));
    on   = b ^ (hit & m_phase);
    rgb  = d ? (on ? fg : bg) : 3'b000;
    return {h, v, rgb};
  endfunction

  // Drive one pixel at the current negedge, queue its expected output,
  // advance one cycle and check the pixel that leaves the pipeline.
  task automatic step(input logic [7:0] c, input logic [7:0] r, input logic h,
                      input logic v, input logic d, input logic use_tab,
                      input logic [2:0] tab_rgb);
    logic [4:0] e, got;
    if (m_prev && !v) begin
      if (m_cnt == BLINK_FRAMES - 1) begin
        m_cnt   = 0;
        m_phase = ~m_phase;
      end else begin
        m_cnt++;
      end
    end
    m_prev = v;
    e = use_tab ? {h, v, tab_rgb} : model_pixel(c, r, h, v, d);
    col = c; row = r; hs = h; vs = v; de = d;
    exp_q.push_back(e);
    @(negedge Clock);
    if (exp_q.size() == PIPE_LATENCY) begin
      e   = exp_q.pop_front();
      got = {hso, vso, red, green, blue};
      n_compared++;
      if (got !== e) begin
        n_mismatched++;
        $display("FAIL pixel_out: got {hs,vs,rgb}=%b expected %b at %0t", got, e, $time);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
  endtask

  // Colours are not pipelined: let in-flight pixels leave before changing.
  task automatic set_colors(input logic [2:0] f, input logic [2:0] b);
    idle(PIPE_LATENCY);
    fg = f;
    bg = b;
  endtask

  task automatic apply_reset(input int n);
    Reset = 1'b1;
    col = 8'd0; row = 8'd0; hs = 1'b1; vs = 1'b1; de = 1'b0;
    m_phase = 1'b1; m_cnt = 0; m_prev = 1'b1;
    exp_q.delete();
    repeat (n) @(negedge Clock);
    n_compared++;
    if ({red, green, blue} !== 3'b000 || hso !== 1'b1 || vso !== 1'b1) begin
      n_mismatched++;
      $display("FAIL reset_outputs: got rgb=%b hs=%b vs=%b expected rgb=000 hs=1 vs=1",
               {red, green, blue}, hso, vso);
    end
    n_compared++;
    if (mem_if.oTextAddr !== 10'd0 || mem_if.oFontAddr !== 11'd0) begin
      n_mismatched++;
      $display("FAIL reset_addrs: got text=%0h font=%0h expected 0 0",
               mem_if.oTextAddr, mem_if.oFontAddr);
    end
    n_compared++;
    if (dut.u_blink.oBlinkPhase !== 1'b1) begin
      n_mismatched++;
      $display("FAIL reset_blink_phase: got %b expected 1", dut.u_blink.oBlinkPhase);
    end
    Reset = 1'b0;
    // Flushed stages drain as blank pixels with inactive syncs.
    for (int i = 0; i < PIPE_LATENCY - 1; i++) exp_q.push_back({1'b1, 1'b1, 3'b000});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset(3);
  endtask

  task automatic test_address();
    step(8'd17, 8'd10, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    n_compared++;
    if (mem_if.oTextAddr !== 10'd34 || trunc_if.oTextAddr !== 4'd2) begin
      n_mismatched++;
      $display("FAIL text_addr: got %0d/%0d expected 34/2", mem_if.oTextAddr, trunc_if.oTextAddr);
    end
    idle(2);
    n_compared++;
    if (mem_if.oFontAddr !== 11'h20A) begin
      n_mismatched++;
      $display("FAIL font_addr: got %h expected 20a", mem_if.oFontAddr);
    end
    // charRow 1, charCol 0: 32 wraps to 0 in a 4-bit address space.
    step(8'd0, 8'd8, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    n_compared++;
    if (mem_if.oTextAddr !== 10'd32 || trunc_if.oTextAddr !== 4'd0) begin
      n_mismatched++;
      $display("FAIL addr_trunc0: got %0d/%0d expected 32/0", mem_if.oTextAddr, trunc_if.oTextAddr);
    end
    step(8'd40, 8'd8, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    n_compared++;
    if (mem_if.oTextAddr !== 10'd37 || trunc_if.oTextAddr !== 4'd5) begin
      n_mismatched++;
      $display("FAIL addr_trunc5: got %0d/%0d expected 37/5", mem_if.oTextAddr, trunc_if.oTextAddr);
    end
  endtask

  task automatic test_pixels();
    logic [2:0] seq [8];
    seq = '{3'd7, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd7};
    set_colors(COLOR_WHITE, 3'b001);
    // Cell (4,2), glyph row 3 holds 8'b1000_0001.
    for (int i = 0; i < 8; i++) step(8'(32 + i), 8'd19, 1'b1, 1'b1, 1'b1, 1'b1, seq[i]);
  endtask

  task automatic test_sync();
    int low_cnt = 0;
    for (int i = 0; i < 96; i++) begin
      step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0,
           1'b1, 3'b000);
      if (hso === 1'b0) low_cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      step(8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000);
      if (hso === 1'b0) low_cnt++;
    end
    n_compared++;
    if (low_cnt != 96) begin
      n_mismatched++;
      $display("FAIL hsync_width: got %0d low cycles expected 96", low_cnt);
    end
  endtask

  task automatic test_blink();
    set_colors(3'b110, 3'b011);
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 8; i++)
        step(8'(16 + i), 8'd8, 1'b1, 1'b1, 1'b1, 1'b1, ((f / 2) % 2 == 0) ? 3'b110 : 3'b011);
      idle(4);
      repeat (2) step(8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
      idle(4);
    end
  endtask

  task automatic test_reset_mid();
    set_colors(COLOR_WHITE, COLOR_BLACK);
    for (int i = 0; i < 6; i++) step(8'd32, 8'd19, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    apply_reset(1);
    for (int i = 0; i < 8; i++) step(8'(32 + i), 8'd19, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
  endtask

  task automatic test_back_to_back();
    set_colors(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    for (int i = 0; i < 200; i++)
      step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 3'b000);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) text_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom_range(0, 255));
    for (int r = 0; r < 8; r++) font_mem[8'h41 * 8 + r] = 8'h00;
    font_mem[8'h55 * 8 + 3] = 8'h81;
    text_mem[34] = 8'h41;
    text_mem[68] = 8'h55;
    fg = COLOR_WHITE; bg = COLOR_BLACK;
    cur_col = 5'd2; cur_row = 5'd1;

    test_reset();
    test_address();
    test_pixels();
    test_sync();
    test_blink();
    test_reset_mid();
    test_back_to_back();
    idle(PIPE_LATENCY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/vga_text_renderer.md
# vga_text_renderer

Text-mode pixel generator sitting directly downstream of the VGA timing controller. It takes the controller's pixel column/row, sync and display-enable signals and fetches a character code from text RAM and a glyph row from font ROM through a fixed 5-cycle pipeline. It drives 3-bit RGB to the DAC pins with hsync/vsync delayed to stay aligned, and overlays a blinking block cursor.

## Interface
- X_WIDTH, 8: width of pixel column input
- Y_WIDTH, 8: width of pixel row input
- COLS, 32: text columns per row (X_SIZE/8)
- ADDR_WIDTH, 10: text RAM address width
- BLINK_FRAMES, 30: frames per cursor blink half-period (≥1)

Ports:
- Clock  in  1  pixel clock
- Reset  in  1  synchronous, active-high
- iCol  in  X_WIDTH  pixel column from timing controller
- iRow  in  Y_WIDTH  pixel row from timing controller
- iHSync  in  1  horizontal sync, active-low
- iVSync  in  1  vertical sync, active-low
- iDisplayEnable  in  1  1 while the pixel is in the visible area
- iFgColor  in  3  foreground {R,G,B}
- iBgColor  in  3  background {R,G,B}
- iCursorCol  in  X_WIDTH-3  cursor character column
- iCursorRow  in  Y_WIDTH-3  cursor character row
- oTextAddr  out  ADDR_WIDTH  text RAM read address (registered)
- iTextData  in  8  character code, valid 1 cycle after oTextAddr
- oFontAddr  out  11  font ROM address {char[7:0], glyphRow[2:0]} (registered)
- iFontData  in  8  glyph row bits, MSB = leftmost pixel, valid 1 cycle after oFontAddr
- oRed, oGreen, oBlue  out  1 each  pixel colour
- oHSync, oVSync  out  1 each  delayed syncs, active-low

## Operation
- Cells are 8×8 pixels. charCol = iCol[X_WIDTH-1:3], charRow = iRow[Y_WIDTH-1:3], glyphRow = iRow[2:0], glyphCol = iCol[2:0].
- Stage 1 (register): oTextAddr = charRow*COLS + charCol, truncated to ADDR_WIDTH; capture glyphRow, glyphCol, syncs, enable, and cursorHit = (charCol==iCursorCol && charRow==iCursorRow).
- Stage 2 (register): copy sideband forward. iTextData is valid during this stage.
- Stage 3 (register): oFontAddr = {iTextData, glyphRow}; copy sideband forward.
- Stage 4 (register): copy sideband forward. iFontData is valid during this stage.
- Stage 5 (output register): bit = iFontData[7-glyphCol]; on = bit XOR (cursorHit & blinkPhase). RGB = enable ? (on ? iFgColor : iBgColor) : 3'b000. oHSync and oVSync take their stage-4 copies.
- iFgColor and iBgColor are sampled at stage 5; they are not pipelined.
- Blink timer: detects a falling edge of iVSync using a registered previous value. On each falling edge, frameCnt increments. When frameCnt == BLINK_FRAMES-1 on an edge, frameCnt goes to 0 and blinkPhase toggles.
- No backpressure. One pixel is accepted every cycle, unconditionally.

## Timing
- Latency from inputs to RGB/sync outputs is exactly 5 cycles for every signal. Sync pulse widths and positions are preserved exactly.
- oTextAddr lags its inputs by 1 cycle. oFontAddr lags its inputs by 3 cycles.
- Reset values:
  - oTextAddr = 0, oFontAddr = 0.
  - RGB = 000; oHSync = oVSync = 1.
  - All pipeline enables = 0; all pipeline syncs = 1.
  - frameCnt = 0, blinkPhase = 1, previous-vsync = 1.
- Reset mid-frame: every pipeline stage is flushed on the same edge. Outputs show black and inactive syncs from the next cycle. The first valid pixel appears 5 cycles after the first non-reset input.
- Wrap-around:
  - Address overflow beyond 2^ADDR_WIDTH truncates silently.
  - frameCnt never exceeds BLINK_FRAMES-1.
  - With BLINK_FRAMES = 1, the phase toggles on every frame.
- Cursor and blanking: when the cursor cell coincides with display-enable = 0, the output is black (blanking wins).
- A vsync falling edge coinciding with Reset is ignored.

## Structure
- Shared definitions: PIPE_LATENCY = 5, CELL_SHIFT = 3, colour constants COLOR_BLACK = 3'b000 and COLOR_WHITE = 3'b111.
- Sub-module `vga_blink_timer`: Clock, Reset, iVSync, oBlinkPhase; parameter BLINK_FRAMES.
- Pipeline stages live in the top module.

## Test plan
- Address generation: iCol = 17, iRow = 10 → oTextAddr = 1*32 + 2 = 34 one cycle later. Then iTextData = 8'h41 → oFontAddr = {8'h41, 3'd2} = 11'h20A two cycles after that.
- Pixel bits: glyph row 8'b1000_0001, fg = 3'b111, bg = 3'b001, enable = 1, over glyphCol 0..7 → RGB sequence 7,1,1,1,1,1,1,7, starting 5 cycles after the glyphCol = 0 input.
- Blanking and sync alignment: an iHSync low pulse of 96 cycles with enable = 0 → oHSync low for 96 cycles delayed by exactly 5 cycles; RGB = 000 throughout.
- Cursor blink: cursor at (2,1) with BLINK_FRAMES = 2 and glyph 8'h00. Expect fg in frames 0–1, bg in frames 2–3, fg again in frames 4–5. The phase flip occurs after the 2nd vsync falling edge.
- Reset mid-frame: assert Reset for 1 cycle during active fg pixels → next cycle RGB = 000, oHSync = oVSync = 1, blinkPhase = 1. Valid pixels resume 5 cycles after release.
- Address truncation: ADDR_WIDTH = 4, charRow = 1, charCol = 0, COLS = 32 → oTextAddr = 0.
